pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage core. It tracks in-flight register writes in a
//  scoreboard and uses it to detect RAW hazards for the instruction in ID. It then drives the
//  stage enables and flushes: load-use/RAW stalls, EX branch/jump redirect, and data-memory freeze.
//  It sits beside ID and consumes the decoder's register fields and the controller's regWR/load info.
// PARAMETERS
//  NREGS    32  architectural registers; x0 never pending
//  WB_DIST  3   cycles from ID->EX issue until the writeback edge (EX, MEM, WB)
//  PERF_W   32  width of the stall performance counter
// PORTS
//  clk        in   1       core clock
//  rst        in   1       synchronous, active-high reset
//  idValid    in   1       ID holds a real instruction
//  idRs1      in   5       ID source 1 index
//  idRs2      in   5       ID source 2 index
//  idUseRs1   in   1       instruction reads rs1
//  idUseRs2   in   1       instruction reads rs2
//  idRd       in   5       ID destination index
//  idRegWR    in   1       instruction writes rd
//  idIsLoad   in   1       instruction is a load
//  exRedirect in   1       EX resolved taken branch/jump (PC target valid in EX)
//  memReq     in   1       MEM stage has an outstanding data access
//  memReady   in   1       data memory completes the access this cycle
//  pcEn       out  1       PC register update enable
//  ifidEn     out  1       IF/ID register enable
//  ifidFlush  out  1       IF/ID bubble insert
//  idexFlush  out  1       ID/EX bubble insert
//  pipeEn     out  1       ID/EX, EX/MEM, MEM/WB advance enable
//  ctrlState  out  2       FSM state, for debug
//  stallCnt   out  PERF_W  saturating count of non-advancing ID cycles
// BEHAVIOUR
//  - freeze = memReq & ~memReady. hazard = idValid & RAW (see CONFIGURATION). issue = ID advances.
//  - FSM (registered, 1 cycle after cause): RUN=0, STALL=1, MEM_WAIT=2.
//    Next state: MEM_WAIT if freeze; else STALL if hazard & ~exRedirect; else RUN.
//    Outputs are combinational from the current-cycle conditions. ctrlState reports the registered state.
//  - Priority each cycle is freeze > exRedirect > hazard > run.
//  - freeze: all enables 0, no flushes, scoreboard holds, exRedirect is held by the frozen EX.
//  - redirect: pcEn=1, ifidEn=1, ifidFlush=1, idexFlush=1, pipeEn=1, no issue (the ID instruction is
//    killed, so its hazard is ignored).
//  - hazard: pcEn=0, ifidEn=0, idexFlush=1, pipeEn=1, no issue.
//  - run: pcEn=ifidEn=pipeEn=1, flushes 0, issue = idValid.
//  - Scoreboard: age[r], 2 bits, 0 = not pending.
//    Ages decrement on every non-freeze cycle. On issue with idRegWR & idRd!=0: age[idRd] <= WB_DIST.
//    The new write overrides the decrement for that register. exLoad/exRd register the issued
//    load's rd, cleared on a non-issue advance.
//  - Reads of x0 never hazard.
//  - stallCnt increments on any freeze or hazard cycle and saturates at all-ones.
//  - Reset (sync, also mid-operation): state RUN, all ages 0, exLoad 0, stallCnt 0.
//    While rst is high: pcEn=ifidEn=pipeEn=0, ifidFlush=idexFlush=1.
// CONFIGURATION
//  PIPE_HAZARD_FWD_EN defined: the datapath forwards EX/MEM/WB results.
//    RAW = source match on exLoad & exRd only, so there is a single load-use bubble.
//  PIPE_HAZARD_FWD_EN undefined: no forwarding.
//    RAW = any used source r with age[r]!=0. The stall lasts until writeback completes (the regfile
//    has no write-through).
// STRUCTURE
//  - pipe_hazard_pkg: ctrl_state_e enum (RUN/STALL/MEM_WAIT), WB_DIST default, AGE_W=2.
//  - Sub-module reg_scoreboard: age array, decrement/issue update, per-port pending lookup.
//  - Top level: FSM, priority/output logic, perf counter.
// TESTING
//  1. Reset held 2 cycles, then released -> ctrlState=0, stallCnt=0, all ages clear, pcEn=1 next cycle.
//  2. FWD_EN: lw x5 issued, next ID add x6,x5,x1 -> exactly 1 cycle with pcEn=0 and idexFlush=1,
//     stallCnt=1, then issue.
//  3. No FWD_EN: addi x5 then add x6,x5,x5 -> 3 stall cycles (ages 3,2,1), issue on the 4th cycle.
//  4. exRedirect coincident with a load-use hazard -> ifidFlush=idexFlush=1, pcEn=1,
//     hazard ignored, no scoreboard write.
//  5. memReq=1, memReady=0 for 4 cycles with age[x7]=2 -> all enables 0, age stays 2, stallCnt+=4;
//     memReady=1 -> resume.
//  6. Source or rd = x0 with idRegWR -> no stall and no scoreboard entry.
//     Assert rst mid-stall -> stall released after reset.

Source files
------------

// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its register scoreboard.
// Pure declarations: no latency, no flow control.
package pipe_hazard_pkg;

  localparam int NREGS_DEF   = 32;
  localparam int WB_DIST_DEF = 3;
  localparam int AGE_W       = 2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// In-flight register write tracker: per-register age countdown to writeback plus the last issued load.
// Lookup is combinational; updates land on the edge of every advancing (non-frozen) cycle, frozen cycles hold.
module reg_scoreboard
  import pipe_hazard_pkg::*;
#(
  parameter int NREGS   = NREGS_DEF,
  parameter int WB_DIST = WB_DIST_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       issue,
  input  logic       wr_en,
  input  logic       wr_load,
  input  logic [4:0] wr_rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       rs1_pend,
  output logic       rs2_pend
);

  logic [AGE_W-1:0] age_q [NREGS];
  logic [AGE_W-1:0] age_d [NREGS];
  logic             ex_load_q, ex_load_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic             wr_real;

  assign wr_real = issue & wr_en & (wr_rd != 5'd0);

  always_comb begin
    age_d     = age_q;
    ex_load_d = ex_load_q;
    ex_rd_d   = ex_rd_q;
    if (advance) begin
      for (int r = 0; r < NREGS; r++) begin
        if (age_q[r] != '0) age_d[r] = age_q[r] - 1'b1;
      end
      // A fresh write restarts the countdown for its register, overriding the decrement.
      if (wr_real) age_d[wr_rd] = AGE_W'(WB_DIST);
      ex_load_d = wr_real & wr_load;
      ex_rd_d   = issue ? wr_rd : ex_rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) age_q[r] <= '0;
      ex_load_q <= 1'b0;
      ex_rd_q   <= 5'd0;
    end else begin
      age_q     <= age_d;
      ex_load_q <= ex_load_d;
      ex_rd_q   <= ex_rd_d;
    end
  end

`ifdef PIPE_HAZARD_FWD_EN
  // Results forward from EX/MEM/WB; only a load still in EX cannot be bypassed.
  assign rs1_pend = (rs1 != 5'd0) & ex_load_q & (rs1 == ex_rd_q);
  assign rs2_pend = (rs2 != 5'd0) & ex_load_q & (rs2 == ex_rd_q);
`else
  // The load-in-EX term is already covered by a non-zero age; kept so both builds share one lookup.
  assign rs1_pend = (rs1 != 5'd0) & ((age_q[rs1] != '0) | (ex_load_q & (rs1 == ex_rd_q)));
  assign rs2_pend = (rs2 != 5'd0) & ((age_q[rs2] != '0) | (ex_load_q & (rs2 == ex_rd_q)));
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: RAW stalls, EX redirect flush, data-memory freeze; enables are same-cycle
// combinational, ctrlState/stallCnt registered. Build option PIPE_HAZARD_FWD_EN selects forwarding hazards.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int NREGS   = NREGS_DEF,
  parameter int WB_DIST = WB_DIST_DEF,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idValid,
  input  logic [4:0]        idRs1,
  input  logic [4:0]        idRs2,
  input  logic              idUseRs1,
  input  logic              idUseRs2,
  input  logic [4:0]        idRd,
  input  logic              idRegWR,
  input  logic              idIsLoad,
  input  logic              exRedirect,
  input  logic              memReq,
  input  logic              memReady,
  output logic              pcEn,
  output logic              ifidEn,
  output logic              ifidFlush,
  output logic              idexFlush,
  output logic              pipeEn,
  output logic [1:0]        ctrlState,
  output logic [PERF_W-1:0] stallCnt
);

  ctrl_state_e       state_q, state_d;
  logic [PERF_W-1:0] cnt_q, cnt_d;
  logic              freeze, hazard, stall, issue, advance;
  logic              rs1_pend, rs2_pend;

  assign freeze  = memReq & ~memReady;
  assign hazard  = idValid & ((idUseRs1 & rs1_pend) | (idUseRs2 & rs2_pend));
  assign stall   = ~freeze & ~exRedirect & hazard;
  assign advance = ~rst & ~freeze;
  assign issue   = advance & ~exRedirect & ~hazard & idValid;

  reg_scoreboard #(.NREGS(NREGS), .WB_DIST(WB_DIST)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .advance  (advance),
    .issue    (issue),
    .wr_en    (idRegWR),
    .wr_load  (idIsLoad),
    .wr_rd    (idRd),
    .rs1      (idRs1),
    .rs2      (idRs2),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend)
  );

  always_comb begin
    pcEn      = 1'b1;
    ifidEn    = 1'b1;
    ifidFlush = 1'b0;
    idexFlush = 1'b0;
    pipeEn    = 1'b1;
    if (rst) begin
      pcEn      = 1'b0;
      ifidEn    = 1'b0;
      pipeEn    = 1'b0;
      ifidFlush = 1'b1;
      idexFlush = 1'b1;
    end else if (freeze) begin
      pcEn   = 1'b0;
      ifidEn = 1'b0;
      pipeEn = 1'b0;
    end else if (exRedirect) begin
      ifidFlush = 1'b1;
      idexFlush = 1'b1;
    end else if (hazard) begin
      pcEn      = 1'b0;
      ifidEn    = 1'b0;
      idexFlush = 1'b1;
    end
  end

  always_comb begin
    if (freeze)     state_d = MEM_WAIT;
    else if (stall) state_d = STALL;
    else            state_d = RUN;
    cnt_d = cnt_q;
    if ((freeze | stall) && (cnt_q != {PERF_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ctrlState = state_q;
  assign stallCnt  = cnt_q;

endmodule
